// File: rtl/freq_wave_detect.sv
// Recovers the 2-bit frequency-select code from a running 10-bit phase stream
// by measuring the number of valid samples between phase wraps.
module freq_wave_detect (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  phase_in,
  input  logic        phase_valid,
  output logic [1:0]  freq_wave,
  output logic [9:0]  phase_step,
  output logic        locked,
  output logic [10:0] period_last,
  output logic        mismatch
);

  localparam int unsigned PhaseW = 10;
  localparam int unsigned CntW   = 11;
  localparam logic [CntW-1:0] CntMax = CntW'(2047);

  typedef enum logic [1:0] {
    ST_SYNC    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_e;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic [PhaseW-1:0] prev_phase_q;
  logic              prev_valid_q;
  logic [1:0]        cand_q;
  logic              cand_ok_q;
  logic [1:0]        freq_wave_q;
  logic [PhaseW-1:0] phase_step_q;
  logic              locked_q;
  logic [CntW-1:0]   period_last_q;
  logic              mismatch_q;

  logic              wrap_c;
  logic [1:0]        cls_c;
  logic              cls_ok_c;
  logic [PhaseW-1:0] step_dec_c;

  assign wrap_c = prev_valid_q && (phase_in < prev_phase_q);

  // Map a completed period length back to its select code.
  always_comb begin
    cls_c    = 2'b00;
    cls_ok_c = 1'b0;
    case (cnt_q)
      CntW'(1024): begin cls_c = 2'b00; cls_ok_c = 1'b1; end
      CntW'(512):  begin cls_c = 2'b01; cls_ok_c = 1'b1; end
      CntW'(256):  begin cls_c = 2'b10; cls_ok_c = 1'b1; end
      default:     begin cls_c = 2'b00; cls_ok_c = 1'b0; end
    endcase
  end

  always_comb begin
    step_dec_c = PhaseW'(1);
    case (freq_wave_q)
      2'b01:   step_dec_c = PhaseW'(2);
      2'b10:   step_dec_c = PhaseW'(4);
      default: step_dec_c = PhaseW'(1);
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_SYNC;
      cnt_q         <= '0;
      prev_phase_q  <= '0;
      prev_valid_q  <= 1'b0;
      cand_q        <= 2'b00;
      cand_ok_q     <= 1'b0;
      freq_wave_q   <= 2'b00;
      phase_step_q  <= PhaseW'(1);
      locked_q      <= 1'b0;
      period_last_q <= '0;
      mismatch_q    <= 1'b0;
    end else begin
      mismatch_q   <= 1'b0;
      phase_step_q <= step_dec_c;
      if (phase_valid) begin
        prev_phase_q <= phase_in;
        prev_valid_q <= 1'b1;
        if (wrap_c) begin
          period_last_q <= cnt_q;
          cnt_q         <= CntW'(1);
          case (state_q)
            ST_SYNC: state_q <= ST_MEASURE;
            ST_MEASURE: begin
              if (cls_ok_c && cand_ok_q && (cls_c == cand_q)) begin
                state_q     <= ST_LOCKED;
                locked_q    <= 1'b1;
                freq_wave_q <= cls_c;
              end else begin
                cand_q    <= cls_c;
                cand_ok_q <= cls_ok_c;
              end
            end
            ST_LOCKED: begin
              if (!(cls_ok_c && (cls_c == freq_wave_q))) begin
                mismatch_q <= 1'b1;
                state_q    <= ST_MEASURE;
                locked_q   <= 1'b0;
                cand_q     <= cls_c;
                cand_ok_q  <= cls_ok_c;
              end
            end
            default: begin
              state_q  <= ST_SYNC;
              locked_q <= 1'b0;
            end
          endcase
        end else if (cnt_q == CntMax) begin
          // No wrap for a full counter range: the stream is stuck, start over.
          state_q   <= ST_SYNC;
          locked_q  <= 1'b0;
          cand_ok_q <= 1'b0;
          if (state_q == ST_LOCKED) mismatch_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q + CntW'(1);
        end
      end
    end
  end

  assign freq_wave   = freq_wave_q;
  assign phase_step  = phase_step_q;
  assign locked      = locked_q;
  assign period_last = period_last_q;
  assign mismatch    = mismatch_q;

endmodule

// File: tb/tb_freq_wave_detect.sv
// Directed/randomized bench for freq_wave_detect; the reference model tracks
// the history of classified periods and locks on two equal valid classes in a row.
module tb_freq_wave_detect;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  phase_in;
  logic        phase_valid;
  logic [1:0]  freq_wave;
  logic [9:0]  phase_step;
  logic        locked;
  logic [10:0] period_last;
  logic        mismatch;

  int checks = 0;
  int errors = 0;

  freq_wave_detect dut (
    .clk        (clk),
    .rst        (rst),
    .phase_in   (phase_in),
    .phase_valid(phase_valid),
    .freq_wave  (freq_wave),
    .phase_step (phase_step),
    .locked     (locked),
    .period_last(period_last),
    .mismatch   (mismatch)
  );

  always #5 clk = ~clk;

  // Reference model state
  int       m_cnt;
  bit       m_prev_valid;
  int       m_prev;
  bit       m_synced;
  int       hist[$];
  int       exp_fw, exp_step, exp_pl;
  bit       exp_lock, exp_mis;

  // Bench bookkeeping
  int       cur_ph;
  int       sample_idx;
  int       mis_cnt;
  bit       lock_seen;
  int       lock_at;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int classify(input int n);
    if (n == 1024) return 0;
    if (n == 512)  return 1;
    if (n == 256)  return 2;
    return -1;
  endfunction

  function automatic int step_of(input int fw);
    return (fw == 1) ? 2 : (fw == 2) ? 4 : 1;
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_prev_valid = 0; m_prev = 0; m_synced = 0;
    hist.delete();
    exp_fw = 0; exp_step = 1; exp_pl = 0; exp_lock = 0; exp_mis = 0;
  endtask

  task automatic model_sample(input bit v, input int ph);
    int n;
    bit nl;
    exp_mis  = 0;
    exp_step = step_of(exp_fw);
    if (!v) return;
    if (m_prev_valid && ph < m_prev) begin
      exp_pl = m_cnt;
      if (!m_synced) m_synced = 1;
      else begin
        hist.push_back(classify(m_cnt));
        n  = hist.size();
        nl = (n >= 2) && (hist[n-1] >= 0) && (hist[n-1] == hist[n-2]);
        if (exp_lock && !nl) exp_mis = 1;
        if (nl) exp_fw = hist[n-1];
        exp_lock = nl;
      end
      m_cnt = 1;
    end else if (m_cnt >= 2047) begin
      if (exp_lock) exp_mis = 1;
      exp_lock = 0;
      m_synced = 0;
      hist.delete();
    end else begin
      m_cnt++;
    end
    m_prev = ph;
    m_prev_valid = 1;
  endtask

  task automatic check_all();
    chk("freq_wave",   32'(freq_wave),   32'(exp_fw));
    chk("phase_step",  32'(phase_step),  32'(exp_step));
    chk("locked",      32'(locked),      32'(exp_lock));
    chk("period_last", 32'(period_last), 32'(exp_pl));
    chk("mismatch",    32'(mismatch),    32'(exp_mis));
  endtask

  // One clock: drive inputs, advance model on the edge, compare 1 time unit later.
  task automatic drive(input bit v, input int ph);
    phase_valid = v;
    phase_in    = 10'(ph);
    @(posedge clk);
    model_sample(v, ph);
    #1;
    if (v) sample_idx++;
    if (mismatch === 1'b1) mis_cnt++;
    if (locked === 1'b1 && !lock_seen) begin
      lock_seen = 1;
      lock_at   = sample_idx;
    end
    check_all();
  endtask

  task automatic run_stream(input int step, input int n_valid, input int gap_pct);
    int done;
    done = 0;
    while (done < n_valid) begin
      if (gap_pct > 0 && $urandom_range(99, 0) < 32'(gap_pct)) begin
        drive(0, int'($urandom_range(1023, 0)));
      end else begin
        drive(1, cur_ph);
        cur_ph = (cur_ph + step) % 1024;
        done++;
      end
    end
  endtask

  task automatic clear_marks();
    mis_cnt = 0; lock_seen = 0; lock_at = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    phase_valid = 1'b0;
    phase_in = '0;
    repeat (3) @(negedge clk);
    model_reset();
    rst = 1'b0;
    @(posedge clk);
    #1;
    sample_idx = 0;
    cur_ph = 0;
    clear_marks();
  endtask

  initial begin
    rst = 1'b1;
    phase_valid = 1'b0;
    phase_in = '0;
    model_reset();
    sample_idx = 0; cur_ph = 0;
    clear_marks();

    // Reset state
    repeat (2) @(negedge clk);
    check_all();
    do_reset();

    // Step 1, continuous, from phase 0
    run_stream(1, 3073 + 300, 0);
    chk("s1_lock_at",    32'(lock_at),     32'd3073);
    chk("s1_freq",       32'(freq_wave),   32'd0);
    chk("s1_step",       32'(phase_step),  32'd1);
    chk("s1_period",     32'(period_last), 32'd1024);
    chk("s1_no_mis",     32'(mis_cnt),     32'd0);

    // Asynchronous reset mid-period while locked
    #2 rst = 1'b1;
    #1;
    chk("rst_freq",   32'(freq_wave),   32'd0);
    chk("rst_step",   32'(phase_step),  32'd1);
    chk("rst_locked", 32'(locked),      32'd0);
    chk("rst_period", 32'(period_last), 32'd0);
    chk("rst_mis",    32'(mismatch),    32'd0);
    do_reset();

    // Step 4 with ~30% valid gaps; re-lock after 3 wraps
    run_stream(4, 769 + 300, 30);
    chk("s4_lock_at", 32'(lock_at),     32'd769);
    chk("s4_freq",    32'(freq_wave),   32'd2);
    chk("s4_step",    32'(phase_step),  32'd4);
    chk("s4_period",  32'(period_last), 32'd256);

    // Step 2 (phase continues), lock on 01, then switch to step 1 mid-period
    run_stream(2, 4 * 512 + 200, 20);
    chk("s2_locked", 32'(locked),    32'd1);
    chk("s2_freq",   32'(freq_wave), 32'd1);
    clear_marks();
    run_stream(1, 1024 - cur_ph + 3, 0);
    chk("sw_mis_once", 32'(mis_cnt),   32'd1);
    chk("sw_unlocked", 32'(locked),    32'd0);
    chk("sw_freq_hold", 32'(freq_wave), 32'd1);
    clear_marks();
    run_stream(1, 2 * 1024, 0);
    chk("sw_relock", 32'(lock_seen),  32'd1);
    chk("sw_freq00", 32'(freq_wave),  32'd0);
    chk("sw_step1",  32'(phase_step), 32'd1);

    // Stuck phase for longer than the counter range
    clear_marks();
    for (int i = 0; i < 2100; i++) drive(1, cur_ph);
    chk("stuck_mis",    32'(mis_cnt), 32'd1);
    chk("stuck_unlock", 32'(locked),  32'd0);

    // Step 3 never locks
    do_reset();
    run_stream(3, 4000, 10);
    chk("s3_never_lock", 32'(lock_seen), 32'd0);
    chk("s3_no_mis",     32'(mis_cnt),   32'd0);
    chk("s3_period", 32'(period_last == 11'd341 || period_last == 11'd342), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/freq_wave_detect.md
# freq_wave_detect

Recovers the frequency-select code from a running phase stream: watches the 10-bit phase accumulator output of the waveform generator, measures the number of valid samples between phase wraps, and decodes it back to the 2-bit `freq_wave` code and its `phase_step`. It is the inverse of the frequency/wave select mapping, where 1024 samples map to code 00, 512 to 01 and 256 to 10. It sits on the monitor side of the generator as a self-check and status source.

## Interface
Parameters: none; all widths are fixed.

- `clk` input 1: system clock; all logic is on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `phase_in` input 10: phase accumulator value; qualified by `phase_valid`.
- `phase_valid` input 1: one phase sample per cycle while high.
- `freq_wave` output 2: last locked code (00/01/10).
- `phase_step` output 10: step for `freq_wave`: 1, 2 or 4.
- `locked` output 1: a stable code has been confirmed.
- `period_last` output 11: sample count of the most recent complete period.
- `mismatch` output 1: one-cycle pulse when lock is lost.

## Operation
- Only cycles with `phase_valid`=1 are samples; with `phase_valid`=0, all state holds.
- `prev_valid` and `prev_phase[9:0]`:
  - The first sample after reset only loads `prev_phase` and sets `prev_valid`.
  - `wrap` = `prev_valid` and `phase_in < prev_phase` (unsigned).
- Period counter `cnt[10:0]`:
  - On a wrap sample, `period_last` <= `cnt` and `cnt` <= 1. The wrap sample is the first sample of the new period.
  - On other samples, `cnt` <= `cnt`+1, saturating at 2047.
  - Step 1 over 0..1023 gives a measured period of 1024.
- Classification of `cnt` at a wrap:
  - 1024 -> 00
  - 512 -> 01
  - 256 -> 10
  - any other value -> INVALID.
- States:
  - SYNC: no wrap seen yet. The first wrap moves to MEASURE. That period is partial, so it is recorded in `period_last` but not classified.
  - MEASURE: at each wrap, classify the period.
    - A valid class equal to `cand` (with `cand_ok`=1) -> LOCKED, `freq_wave` <= class.
    - Otherwise `cand` <= class, and `cand_ok` <= (class valid).
  - LOCKED: at each wrap, classify the period.
    - A class equal to `freq_wave` -> stay in LOCKED.
    - Any other class, including INVALID -> `mismatch` pulse, go to MEASURE with `cand` <= class and `cand_ok` <= (class valid).
    - `freq_wave` holds its old value.
  - Any state: if `cnt` would exceed 2047 (no wrap for 2047 samples), go to SYNC and clear `cand_ok`. `mismatch` pulses only if the state was LOCKED.
- `locked` = (state == LOCKED).
- `phase_step` is a registered decode of `freq_wave`: 00->1, 01->2, 10->4; 11 never occurs and decodes to 1.
- A wrap and a timeout never coincide, because a wrap resets `cnt`.

## Timing
- Reset values:
  - `freq_wave`=00, `phase_step`=1, `locked`=0, `period_last`=0, `mismatch`=0
  - state=SYNC, `cnt`=0, `prev_valid`=0, `cand_ok`=0.
- All outputs are registered.
  - `period_last`, `locked`, `freq_wave` and `mismatch` update on the clock edge that samples the wrap sample, so they are visible the cycle after it is presented.
  - `phase_step` follows `freq_wave` one cycle later.
- Lock latency from reset with a clean stream starting at phase 0 and step 1:
  - first wrap at sample 1025 (SYNC->MEASURE);
  - candidate set at the second wrap;
  - lock at the third wrap, which is sample 1 + 3×1024.
- `mismatch` is exactly one cycle wide, even if `phase_valid` is low on the following cycle.
- Asserting `rst` mid-period immediately returns all state to reset values; re-sync starts from scratch.
- Gaps in `phase_valid` do not affect the count, because only valid samples are counted.

## Test plan
- Step 1 stream from phase 0, `phase_valid`=1 continuously -> `period_last`=1024; `locked` rises one cycle after sample 3073; `freq_wave`=00; `phase_step`=1 one cycle later.
- Step 4 stream with random `phase_valid` gaps (about 30% low) -> `locked` after 3 wraps; `freq_wave`=10; `phase_step`=4; `period_last`=256.
- Locked on step 2, then switch to step 1 mid-period:
  - The first transitional period is neither 512 nor 1024 -> `mismatch` = one pulse, `locked`=0, `freq_wave` stays 01.
  - Relock to 00 after the next two matching 1024 periods.
- Locked on step 1, then hold `phase_in` constant for 2047 samples -> state SYNC, one `mismatch` pulse, `locked`=0.
- Step 3 stream (period not 256/512/1024) -> never locks; `mismatch` stays 0; `period_last` reports the measured count (341 or 342).
- `rst` pulse while `locked`=1 and mid-period -> all outputs return to reset values asynchronously; lock is re-acquired after 3 wraps.
